// File: rtl/packet_commit_fifo.sv
// Packet FIFO with commit semantics.
// Words of the packet being received are stored, but the reader cannot see
// them until the packet's last word arrives without an error flag. An errored
// or overflowing packet is removed by moving the write pointer back to the
// last commit point. The read side only ever sees whole, good packets.
module packet_commit_fifo #(
  parameter int D_WIDTH      = 8,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // write side
  input  logic [D_WIDTH-1:0]         up_data,
  input  logic                       up_last,
  input  logic                       up_user,
  input  logic                       up_valid,
  output logic                       up_ready,
  // read side
  output logic [D_WIDTH-1:0]         down_data,
  output logic                       down_last,
  output logic                       down_valid,
  input  logic                       down_ready,
  // status
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count,
  output logic                       drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       pkt_count_q, pkt_count_d;
  logic [PW-1:0]       level_q, level_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                drop_pulse_q, drop_pulse_d;

  // Payload plus last flag per word; contents are deliberately not reset.
  logic [D_WIDTH:0]    mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Derived status
  // --------------------------------------------------------------------------
  logic [PW-1:0]       used_w;
  logic                full_w;
  logic                wr_fire_w;
  logic                rd_fire_w;
  logic                pop_last_w;

  // Write-side control decoded from the FSM
  logic                store_w;
  logic                commit_w;
  logic                drop_w;
  logic                rewind_w;

  // Fullness only looks at registered pointers, so a pop in the same cycle
  // never makes room for a write in that cycle.
  assign used_w = wr_ptr_q - rd_ptr_q;
  assign full_w = (used_w == DEPTH_PTR);

  generate
    if (DROP_ON_FULL != 0) begin : g_drop_mode
      assign up_ready = 1'b1;
    end else begin : g_bp_mode
      // While full, keep accepting if nothing committed is waiting: the whole
      // storage holds one oversized packet, which only a drop can resolve.
      assign up_ready = !full_w
                     || (state_q == ST_DISCARD)
                     || (commit_ptr_q == rd_ptr_q);
    end
  endgenerate

  assign wr_fire_w = up_valid && up_ready;

  // Uncommitted words sit between commit_ptr and wr_ptr and are never shown.
  assign down_valid = (rd_ptr_q != commit_ptr_q);
  assign {down_last, down_data} = mem_q[rd_ptr_q[AW-1:0]];

  assign rd_fire_w  = down_valid && down_ready;
  assign pop_last_w = rd_fire_w && down_last;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter DISCARD when a packet is cut short by a full buffer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCEPT: begin
        if (wr_fire_w && !(up_last && up_user) && full_w && !up_last) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (wr_fire_w && up_last) begin
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // FSM outputs: what the accepted word does to storage and pointers
  always_comb begin
    store_w  = 1'b0;
    commit_w = 1'b0;
    drop_w   = 1'b0;
    rewind_w = 1'b0;
    if (state_q == ST_ACCEPT && wr_fire_w) begin
      if (up_last && up_user) begin
        // Error-terminated packet, full or not.
        drop_w   = 1'b1;
        rewind_w = 1'b1;
      end else if (full_w) begin
        // No room for this word, so the whole packet goes.
        drop_w   = 1'b1;
        rewind_w = 1'b1;
      end else begin
        store_w  = 1'b1;
        commit_w = up_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointer and counter update
  // --------------------------------------------------------------------------

  // Next values of pointers, packet count, level and drop statistics
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (rewind_w) begin
      wr_ptr_d = commit_ptr_q;
    end else if (store_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    commit_ptr_d = commit_ptr_q;
    if (commit_w) begin
      commit_ptr_d = wr_ptr_q + PTR_ONE;
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_fire_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // A commit and a packet-end pop in the same cycle cancel out.
    pkt_count_d = pkt_count_q;
    unique case ({commit_w, pop_last_w})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase

    level_d = wr_ptr_d - rd_ptr_d;

    drop_count_d = drop_count_q;
    if (drop_w && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end

    drop_pulse_d = drop_w;
  end

  // Control registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      level_q      <= '0;
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      level_q      <= level_d;
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  // Storage write; only words that are kept are written
  always_ff @(posedge clk) begin
    if (store_w) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {up_last, up_data};
    end
  end

  assign pkt_count  = pkt_count_q;
  assign level      = level_q;
  assign drop_count = drop_count_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_packet_commit_fifo.sv
// Bench for packet_commit_fifo with D_WIDTH=8, DEPTH=4.
// Instance a drops on full, instance b applies backpressure.
module tb_packet_commit_fifo;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int PW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] a_up_data  = '0;
  logic          a_up_last  = 1'b0;
  logic          a_up_user  = 1'b0;
  logic          a_up_valid = 1'b0;
  logic          a_up_ready;
  logic [DW-1:0] a_down_data;
  logic          a_down_last;
  logic          a_down_valid;
  logic          a_down_ready = 1'b0;
  logic [PW-1:0] a_pkt_count;
  logic [PW-1:0] a_level;
  logic [15:0]   a_drop_count;
  logic          a_drop_pulse;

  logic [DW-1:0] b_up_data  = '0;
  logic          b_up_last  = 1'b0;
  logic          b_up_user  = 1'b0;
  logic          b_up_valid = 1'b0;
  logic          b_up_ready;
  logic [DW-1:0] b_down_data;
  logic          b_down_last;
  logic          b_down_valid;
  logic          b_down_ready = 1'b0;
  logic [PW-1:0] b_pkt_count;
  logic [PW-1:0] b_level;
  logic [15:0]   b_drop_count;
  logic          b_drop_pulse;

  int vecs = 0;
  int errs = 0;
  int a_pulses = 0;
  int b_pulses = 0;
  bit pc_bound = 1'b0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  packet_commit_fifo #(.D_WIDTH(DW), .DEPTH(DEP), .DROP_ON_FULL(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .up_data(a_up_data), .up_last(a_up_last), .up_user(a_up_user),
    .up_valid(a_up_valid), .up_ready(a_up_ready),
    .down_data(a_down_data), .down_last(a_down_last),
    .down_valid(a_down_valid), .down_ready(a_down_ready),
    .pkt_count(a_pkt_count), .level(a_level),
    .drop_count(a_drop_count), .drop_pulse(a_drop_pulse)
  );

  packet_commit_fifo #(.D_WIDTH(DW), .DEPTH(DEP), .DROP_ON_FULL(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .up_data(b_up_data), .up_last(b_up_last), .up_user(b_up_user),
    .up_valid(b_up_valid), .up_ready(b_up_ready),
    .down_data(b_down_data), .down_last(b_down_last),
    .down_valid(b_down_valid), .down_ready(b_down_ready),
    .pkt_count(b_pkt_count), .level(b_level),
    .drop_count(b_drop_count), .drop_pulse(b_drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read-side scoreboards
  always @(negedge clk) begin
    if (rst_n && a_down_valid && a_down_ready) begin
      if (qa.size() == 0) begin
        check_eq("a_unexpected_word", 32'(a_down_data), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = qa.pop_front();
        check_eq("a_data", 32'(a_down_data), 32'(e[7:0]));
        check_eq("a_last", 32'(a_down_last), 32'(e[8]));
      end
    end
    if (rst_n && pc_bound) check_eq("a_pkt_bound", 32'(a_pkt_count <= 3'd2), 1);
    if (a_drop_pulse === 1'b1) a_pulses++;
  end

  always @(negedge clk) begin
    if (rst_n && b_down_valid && b_down_ready) begin
      if (qb.size() == 0) begin
        check_eq("b_unexpected_word", 32'(b_down_data), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = qb.pop_front();
        check_eq("b_data", 32'(b_down_data), 32'(e[7:0]));
        check_eq("b_last", 32'(b_down_last), 32'(e[8]));
      end
    end
    if (b_drop_pulse === 1'b1) b_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One write handshake; returns 1 time unit after the accepting edge.
  task automatic wr_word(input int sel, input logic [7:0] d, input logic last, input logic user);
    int  n;
    logic rdy;
    if (sel == 0) begin
      a_up_valid = 1'b1; a_up_data = d; a_up_last = last; a_up_user = user;
    end else begin
      b_up_valid = 1'b1; b_up_data = d; b_up_last = last; b_up_user = user;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (sel == 0) ? a_up_ready : b_up_ready;
      n++;
    end
    if (!rdy) check_eq("wr_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      a_up_valid = 1'b0; a_up_last = 1'b0; a_up_user = 1'b0;
    end else begin
      b_up_valid = 1'b0; b_up_last = 1'b0; b_up_user = 1'b0;
    end
  endtask

  task automatic send_pkt(input int sel, input logic [7:0] base, input int len,
                          input logic err, input logic expect_commit);
    for (int j = 0; j < len; j++) begin
      logic [7:0] d;
      logic       lst;
      d   = base + 8'(j);
      lst = (j == len - 1);
      wr_word(sel, d, lst, lst & err);
    end
    if (expect_commit) begin
      for (int j = 0; j < len; j++) begin
        logic [7:0] d;
        d = base + 8'(j);
        if (sel == 0) qa.push_back({(j == len - 1), d});
        else          qb.push_back({(j == len - 1), d});
      end
    end
  endtask

  task automatic wait_drain(input int sel);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (sel == 0) done = (qa.size() == 0) && !a_down_valid;
      else          done = (qb.size() == 0) && !b_down_valid;
    end
    check_eq(sel == 0 ? "a_drain" : "b_drain", 32'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);

    // Asynchronous reset in the middle of a packet
    wr_word(0, 8'hE0, 1'b0, 1'b0);
    wr_word(0, 8'hE1, 1'b0, 1'b0);
    check_eq("pre_reset_level", 32'(a_level), 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_down_valid", 32'(a_down_valid), 0);
    check_eq("rst_level", 32'(a_level), 0);
    check_eq("rst_pkt_count", 32'(a_pkt_count), 0);
    check_eq("rst_drop_count", 32'(a_drop_count), 0);
    check_eq("rst_up_ready_a", 32'(a_up_ready), 1);
    check_eq("rst_up_ready_b", 32'(b_up_ready), 1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check_eq("post_rst_drop_count", 32'(a_drop_count), 0);
    check_eq("post_rst_level", 32'(a_level), 0);

    // Commit then read a 3-word packet
    a_down_ready = 1'b0;
    wr_word(0, 8'h11, 1'b0, 1'b0);
    wr_word(0, 8'h22, 1'b0, 1'b0);
    check_eq("commit_hidden", 32'(a_down_valid), 0);
    wr_word(0, 8'h33, 1'b1, 1'b0);
    qa.push_back({1'b0, 8'h11});
    qa.push_back({1'b0, 8'h22});
    qa.push_back({1'b1, 8'h33});
    check_eq("commit_visible", 32'(a_down_valid), 1);
    check_eq("commit_pkt_count", 32'(a_pkt_count), 1);
    check_eq("commit_level", 32'(a_level), 3);
    a_down_ready = 1'b1;
    wait_drain(0);
    check_eq("read_pkt_count", 32'(a_pkt_count), 0);
    check_eq("read_level", 32'(a_level), 0);

    // Error-flagged packet is dropped
    p0 = a_pulses;
    wr_word(0, 8'h44, 1'b0, 1'b0);
    wr_word(0, 8'h55, 1'b0, 1'b0);
    wr_word(0, 8'h66, 1'b1, 1'b1);
    tick(2);
    check_eq("err_down_valid", 32'(a_down_valid), 0);
    check_eq("err_level", 32'(a_level), 0);
    check_eq("err_drop_count", 32'(a_drop_count), 1);
    check_eq("err_pulses", 32'(a_pulses - p0), 1);

    // Overflow with drop-on-full
    a_down_ready = 1'b0;
    p0 = a_pulses;
    send_pkt(0, 8'hA0, 2, 1'b0, 1'b1);
    send_pkt(0, 8'hB0, 4, 1'b0, 1'b0);
    tick(1);
    check_eq("ovf_drop_count", 32'(a_drop_count), 2);
    check_eq("ovf_pulses", 32'(a_pulses - p0), 1);
    check_eq("ovf_level", 32'(a_level), 2);
    check_eq("ovf_pkt_count", 32'(a_pkt_count), 1);
    a_down_ready = 1'b1;
    wait_drain(0);
    send_pkt(0, 8'hC0, 3, 1'b0, 1'b1);
    wait_drain(0);
    check_eq("ovf_after_drop_count", 32'(a_drop_count), 2);

    // Back-to-back packets with concurrent reads, wrapping the pointers
    pc_bound = 1'b1;
    for (int p = 0; p < 20; p++) begin
      send_pkt(0, 8'(p * 8), 3, 1'b0, 1'b1);
    end
    wait_drain(0);
    pc_bound = 1'b0;
    check_eq("stream_drop_count", 32'(a_drop_count), 2);
    check_eq("stream_level", 32'(a_level), 0);
    check_eq("stream_pkt_count", 32'(a_pkt_count), 0);

    // Oversize packet with backpressure mode
    b_down_ready = 1'b0;
    p0 = b_pulses;
    for (int j = 0; j < 6; j++) begin
      wr_word(1, 8'(8'h60 + j), (j == 5), 1'b0);
      check_eq("b_oversize_ready", 32'(b_up_ready), 1);
    end
    tick(1);
    check_eq("b_oversize_level", 32'(b_level), 0);
    check_eq("b_oversize_drop_count", 32'(b_drop_count), 1);
    check_eq("b_oversize_pulses", 32'(b_pulses - p0), 1);
    check_eq("b_oversize_valid", 32'(b_down_valid), 0);

    // Backpressure while a committed packet occupies space
    send_pkt(1, 8'h70, 2, 1'b0, 1'b1);
    wr_word(1, 8'h80, 1'b0, 1'b0);
    wr_word(1, 8'h81, 1'b0, 1'b0);
    check_eq("b_full_level", 32'(b_level), 4);
    b_up_valid = 1'b1; b_up_data = 8'h82; b_up_last = 1'b1; b_up_user = 1'b0;
    tick(3);
    check_eq("b_full_not_ready", 32'(b_up_ready), 0);
    check_eq("b_full_level_hold", 32'(b_level), 4);
    qb.push_back({1'b0, 8'h80});
    qb.push_back({1'b0, 8'h81});
    qb.push_back({1'b1, 8'h82});
    b_down_ready = 1'b1;
    wr_word(1, 8'h82, 1'b1, 1'b0);
    wait_drain(1);
    check_eq("b_bp_drop_count", 32'(b_drop_count), 1);
    check_eq("b_bp_level", 32'(b_level), 0);
    check_eq("b_bp_pkt_count", 32'(b_pkt_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/packet_commit_fifo.md
PACKET_COMMIT_FIFO -- requirements
Module: packet_commit_fifo

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: storage words; power of 2, at least 2.
REQ-003 SHALL have parameter DROP_ON_FULL, default 1: 1 = up_ready tied high and overflowing packets dropped; 0 = backpressure.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 up_data  input  D_WIDTH  write payload.
REQ-007 up_last  input  1  final word of packet.
REQ-008 up_user  input  1  error flag, sampled only with up_last: 1 = drop packet.
REQ-009 up_valid / up_ready  input / output  1 each  write handshake; word transfers when both are high.
REQ-010 down_data  output  D_WIDTH  head-of-queue payload.
REQ-011 down_last  output  1  head word is a packet end.
REQ-012 down_valid / down_ready  output / input  1 each  read handshake.
REQ-013 pkt_count  output  $clog2(DEPTH)+1  committed packets not yet fully read.
REQ-014 level  output  $clog2(DEPTH)+1  words stored, committed plus uncommitted.
REQ-015 drop_count  output  16  dropped packets; saturates at 0xFFFF.
REQ-016 drop_pulse  output  1  one-cycle strobe per dropped packet.

Function
REQ-017 Storage SHALL be a DEPTH x (D_WIDTH+1) array holding payload and last bit, addressed by three pointers of $clog2(DEPTH)+1 bits: wr_ptr, commit_ptr, rd_ptr.
REQ-018 full SHALL be (wr_ptr - rd_ptr) == DEPTH and SHALL be computed from registered pointers; a same-cycle pop never frees space for a same-cycle write.
REQ-019 level SHALL equal wr_ptr - rd_ptr, registered.
REQ-020 Write state machine SHALL have states ACCEPT and DISCARD.
REQ-021 ACCEPT, not full, non-last word: store at wr_ptr; increment wr_ptr.
REQ-022 ACCEPT, not full, up_last=1 and up_user=0: store with last=1; then commit_ptr <= wr_ptr+1 and wr_ptr <= wr_ptr+1; increment pkt_count.
REQ-023 ACCEPT, up_last=1 and up_user=1: word not stored; wr_ptr <= commit_ptr; count one drop; applies regardless of full.
REQ-024 ACCEPT, full, word arriving without up_user error: word not stored; wr_ptr <= commit_ptr; count one drop; go to DISCARD if up_last=0, else stay in ACCEPT.
REQ-025 DISCARD: accept and discard every word, with no further drop count; return to ACCEPT after the up_last handshake.
REQ-026 up_ready with DROP_ON_FULL=1 SHALL be constant 1.
REQ-027 up_ready with DROP_ON_FULL=0 SHALL be 1 when !full, or in DISCARD, or when full with commit_ptr == rd_ptr (oversize packet, resolved by REQ-024); otherwise 0.
REQ-028 down_valid SHALL be (rd_ptr != commit_ptr), so uncommitted words are never visible.
REQ-029 down_data and down_last SHALL be the contents at rd_ptr, zero latency from the pointer.
REQ-030 A packet SHALL become visible on the cycle after its committing handshake.
REQ-031 Read handshake SHALL increment rd_ptr; if down_last=1, pkt_count decrements.
REQ-032 Same-cycle commit and last-word pop SHALL leave pkt_count unchanged.
REQ-033 Counting a drop SHALL mean drop_pulse=1 for that cycle and drop_count+1, saturating.
REQ-034 Pointer arithmetic SHALL be modulo 2^($clog2(DEPTH)+1); the array index is the low $clog2(DEPTH) bits; wrap-around is transparent.

Reset
REQ-035 rst_n low SHALL asynchronously clear all pointers, pkt_count, level, drop_count and drop_pulse, and set state to ACCEPT.
REQ-036 During reset, down_valid SHALL be 0 and up_ready SHALL be 1; array contents are not reset.
REQ-037 Reset mid-packet SHALL discard all stored data without counting a drop.

Verification (D_WIDTH=8, DEPTH=4)
REQ-038 Reset: assert rst_n=0 asynchronously -> down_valid=0, level=0, pkt_count=0, drop_count=0, up_ready=1.
REQ-039 Commit: write 0x11, 0x22, 0x33 (last, user=0) -> down_valid rises the cycle after 0x33; reads return 0x11, 0x22, 0x33 with down_last on 0x33; pkt_count goes 1 then 0.
REQ-040 Error drop: write 0x44, 0x55, then last with user=1 -> down_valid stays 0; level returns to 0; drop_count=1; one drop_pulse.
REQ-041 Overflow, DROP_ON_FULL=1: commit 2-word packet, then 4-word packet with no reads -> third word drops it; fourth word discarded; drop_count=1; only the first packet is read out; next packet is accepted normally.
REQ-042 Oversize, DROP_ON_FULL=0: 6-word packet with no reads -> up_ready stays 1; fifth word drops the packet; sixth word discarded; level=0.
REQ-043 Simultaneous events and wrap-around: 3-word packets back-to-back, with reads concurrent with commits, for 20 packets -> data order preserved; pkt_count never exceeds 1 plus in-flight packets; no drops.
